// File: rtl/led_frame_shift_latch.sv
// Multi-channel serial-to-parallel receiver: shifts each sdi lane while en_n is low
// and atomically latches a complete WIDTH-bit frame; short frames are flagged and dropped.
module led_frame_shift_latch #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       sdi,
  input  logic                      en_n,
  output logic [CHANNELS*WIDTH-1:0] latch_out,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [WIDTH-1:0]          sr      [CHANNELS];
  logic [WIDTH-1:0]          sr_n    [CHANNELS];
  logic [WIDTH-1:0]          sh      [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] latch_n;
  logic                      valid_n, err_n;

  // Candidate value of every lane if the current sdi bit is accepted.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (LSB_FIRST != 0) sh[c] = {sdi[c], sr[c][WIDTH-1:1]};
      else                sh[c] = {sr[c][WIDTH-2:0], sdi[c]};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    latch_n = latch_out;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!en_n) begin
          sr_n    = sh;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end else begin
          cnt_n = '0;
          for (int unsigned c = 0; c < CHANNELS; c++) sr_n[c] = '0;
        end
      end
      SHIFT: begin
        if (!en_n) begin
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit goes straight to the latch on the same edge it is sampled.
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              latch_n[c*WIDTH +: WIDTH] = sh[c];
              sr_n[c]                   = '0;
            end
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            sr_n  = sh;
            cnt_n = cnt + CW'(1);
          end
        end else begin
          err_n = 1'b1;
          cnt_n = '0;
          for (int unsigned c = 0; c < CHANNELS; c++) sr_n[c] = '0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (en_n) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      latch_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) sr[c] <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      latch_out   <= latch_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
      for (int unsigned c = 0; c < CHANNELS; c++) sr[c] <= sr_n[c];
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_led_frame_shift_latch.sv
// Bench for led_frame_shift_latch: MSB-first and LSB-first instances share stimulus
// and are compared against a queue-based frame model.
module tb_led_frame_shift_latch;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_n = 1'b1;
  logic [1:0]  sdi = 2'b00;
  logic [15:0] latch_m, latch_l;
  logic        valid_m, err_m, busy_m, valid_l, err_l, busy_l;

  int checks = 0;
  int failures = 0;

  // Model state: bits of the frame in progress, and whether we wait for en_n high.
  logic [1:0]  q[$];
  bit          hold = 0;
  logic [15:0] exp_m = '0, exp_l = '0;
  logic        exp_valid = 0, exp_err = 0, exp_busy = 0;

  always #5 clk = ~clk;

  led_frame_shift_latch #(.WIDTH(8), .CHANNELS(2), .LSB_FIRST(0)) dut_m (
    .clk(clk), .reset(reset), .sdi(sdi), .en_n(en_n),
    .latch_out(latch_m), .frame_valid(valid_m), .frame_err(err_m), .busy(busy_m));

  led_frame_shift_latch #(.WIDTH(8), .CHANNELS(2), .LSB_FIRST(1)) dut_l (
    .clk(clk), .reset(reset), .sdi(sdi), .en_n(en_n),
    .latch_out(latch_l), .frame_valid(valid_l), .frame_err(err_l), .busy(busy_l));

  task automatic model_update();
    exp_valid = 0;
    exp_err   = 0;
    if (!reset) begin
      q.delete();
      hold = 0;
      exp_m = '0;
      exp_l = '0;
    end else if (hold) begin
      if (en_n) hold = 0;
    end else if (!en_n) begin
      q.push_back(sdi);
      if (q.size() == W) begin
        for (int i = 0; i < W; i++)
          for (int c = 0; c < 2; c++) begin
            exp_m[c*W + (W-1-i)] = q[i][c];
            exp_l[c*W + i]       = q[i][c];
          end
        exp_valid = 1;
        q.delete();
        hold = 1;
      end
    end else if (q.size() > 0) begin
      exp_err = 1;
      q.delete();
    end
    exp_busy = (q.size() > 0);
  endtask

  task automatic step(input logic [1:0] d, input logic e);
    @(negedge clk);
    sdi  = d;
    en_n = e;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2'b11, 1'b0);
    step(2'b10, 1'b0);
    checks++; if (latch_m !== 16'h0 || latch_l !== 16'h0) begin
      failures++; $display("FAIL reset_latch got=%h/%h want=0000", latch_m, latch_l); end
    checks++; if ({valid_m, err_m, busy_m, valid_l, err_l, busy_l} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=000000",
        {valid_m, err_m, busy_m, valid_l, err_l, busy_l}); end
    reset = 1'b1;
    step(2'b00, 1'b1);
  endtask

  task automatic test_frame();
    logic [7:0] p0 = 8'b10100101, p1 = 8'b11110000;
    int nv = 0, ne = 0;
    for (int i = 0; i < W; i++) begin
      step({p1[7-i], p0[7-i]}, 1'b0);
      nv += int'(valid_m); ne += int'(err_m) + int'(err_l);
    end
    checks++; if (latch_m !== 16'hF0A5 || latch_m !== exp_m) begin
      failures++; $display("FAIL frame_msb got=%h want=f0a5", latch_m); end
    checks++; if (latch_l !== 16'h0FA5 || latch_l !== exp_l) begin
      failures++; $display("FAIL frame_lsb got=%h want=0fa5", latch_l); end
    checks++; if (valid_m !== 1'b1 || valid_l !== 1'b1) begin
      failures++; $display("FAIL frame_valid got=%b/%b want=1", valid_m, valid_l); end
    step(2'($urandom), 1'b1);
    nv += int'(valid_m); ne += int'(err_m) + int'(err_l);
    checks++; if (nv !== 1 || ne !== 0) begin
      failures++; $display("FAIL frame_pulses got=valid%0d err%0d want=valid1 err0", nv, ne); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      step(2'($urandom), 1'b0);
      checks++; if (busy_m !== exp_busy || busy_l !== exp_busy || err_m !== 1'b0) begin
        failures++; $display("FAIL abort_busy got=%b/%b want=%b", busy_m, busy_l, exp_busy); end
    end
    step(2'($urandom), 1'b1);
    checks++; if (err_m !== 1'b1 || err_l !== 1'b1 || err_m !== exp_err || valid_m !== 1'b0) begin
      failures++; $display("FAIL abort_err got=%b/%b want=1", err_m, err_l); end
    checks++; if (latch_m !== 16'hF0A5 || latch_l !== 16'h0FA5) begin
      failures++; $display("FAIL abort_latch got=%h/%h want=f0a5/0fa5", latch_m, latch_l); end
    checks++; if (busy_m !== 1'b0 || busy_l !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=%b/%b want=0", busy_m, busy_l); end
    step(2'b00, 1'b1);
    checks++; if (err_m !== 1'b0 || err_l !== 1'b0) begin
      failures++; $display("FAIL abort_pulse_width got=%b/%b want=0", err_m, err_l); end
  endtask

  task automatic test_hold();
    logic [7:0] p = 8'h3C;
    int nv = 0;
    for (int i = 0; i < 12; i++) begin
      step({1'($urandom), 1'b1}, 1'b0);
      nv += int'(valid_m);
    end
    checks++; if (latch_m[7:0] !== 8'hFF || latch_l[7:0] !== 8'hFF || latch_m !== exp_m) begin
      failures++; $display("FAIL hold_ch0 got=%h/%h want=ff", latch_m[7:0], latch_l[7:0]); end
    checks++; if (nv !== 1 || busy_m !== 1'b0) begin
      failures++; $display("FAIL hold_single got=valid%0d busy%b want=valid1 busy0", nv, busy_m); end
    step(2'b00, 1'b1);
    for (int i = 0; i < W; i++) step({1'($urandom), p[7-i]}, 1'b0);
    checks++; if (latch_m[7:0] !== 8'h3C || latch_l[7:0] !== 8'h3C || latch_l !== exp_l) begin
      failures++; $display("FAIL hold_next got=%h/%h want=3c", latch_m[7:0], latch_l[7:0]); end
    step(2'b00, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(2'($urandom), 1'b0);
    reset = 1'b0;
    step(2'($urandom), 1'b0);
    checks++; if ({latch_m, latch_l} !== 32'h0 || {valid_m, err_m, busy_m} !== 3'b0) begin
      failures++; $display("FAIL reset_mid got=%h/%h flags=%b want=0", latch_m, latch_l,
        {valid_m, err_m, busy_m}); end
    reset = 1'b1;
    step(2'b00, 1'b1);
    checks++; if (err_m !== 1'b0) begin
      failures++; $display("FAIL reset_mid_err got=%b want=0", err_m); end
    for (int i = 0; i < W; i++) step(2'($urandom), 1'b0);
    checks++; if (latch_m !== exp_m || latch_l !== exp_l || valid_m !== 1'b1) begin
      failures++; $display("FAIL reset_mid_frame got=%h/%h want=%h/%h", latch_m, latch_l,
        exp_m, exp_l); end
    step(2'b00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int nv = 0, ne = 0;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < W; i++) begin
        step(2'($urandom), 1'b0);
        nv += int'(valid_m) + int'(valid_l); ne += int'(err_m) + int'(err_l);
      end
      checks++; if (latch_m !== exp_m || latch_l !== exp_l) begin
        failures++; $display("FAIL b2b_frame%0d got=%h/%h want=%h/%h", f, latch_m, latch_l,
          exp_m, exp_l); end
      step(2'($urandom), 1'b1);
      nv += int'(valid_m) + int'(valid_l); ne += int'(err_m) + int'(err_l);
      checks++; if (latch_m !== exp_m || latch_l !== exp_l) begin
        failures++; $display("FAIL b2b_holdval%0d got=%h/%h want=%h/%h", f, latch_m, latch_l,
          exp_m, exp_l); end
    end
    checks++; if (nv !== 20 || ne !== 0) begin
      failures++; $display("FAIL b2b_pulses got=valid%0d err%0d want=valid20 err0", nv, ne); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_abort();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
